// File: rtl/spi_ram_burst_slave.sv
// spi_ram_burst_slave
//   SPI-framed burst RAM slave. Each frame starts with a 2-bit opcode
//   (01 burst write, 10 burst read), followed by an ADDR_WIDTH-bit start
//   address. Then data words stream in on MOSI (write) or out on MISO (read).
//   The address auto-increments and wraps at MEM_DEPTH. All shifting is MSB
//   first, and everything is sampled on the rising edge of clk.
//
//   Optional feature: define SPI_RAM_PARITY_EN to append one even-parity
//   bit to every data word in both directions. A write word whose parity
//   bit does not match is not stored, but the address still advances.
//
// Ports
//   clk   : single clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   SS_n  : active-low slave select that frames a transaction
//   MOSI  : serial data in, sampled while SS_n is low
//   MISO  : registered serial data out, 0 outside the read data phase
module spi_ram_burst_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

`ifdef SPI_RAM_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int WORD_BITS = DATA_WIDTH + PARITY_BITS;
  localparam int SH_MAX    = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int SH_W      = (SH_MAX < 2) ? 2 : SH_MAX;
  localparam int CNT_W     = 6;

  localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      WORD_LAST = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0]      PAR_IDX   = CNT_W'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RWAIT, RDATA, DISCARD} state_t;

  state_t                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic                    rd_q, rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SH_W-1:0]         rx_q, rx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    txpar_q, txpar_d;
  logic                    miso_q, miso_d;
  logic                    pend_q, pend_d;
  logic                    pend_ok_q, pend_ok_d;
  logic [DATA_WIDTH-1:0]   wword_q, wword_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [SH_W-1:0]         shift_in;
  logic [ADDR_WIDTH-1:0]   addr_full;
  logic                    addr_ok;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [DATA_WIDTH-1:0]   rd_cur, rd_next;
  logic                    mem_we;

  assign shift_in  = {rx_q[SH_W-2:0], MOSI};
  assign addr_full = shift_in[ADDR_WIDTH-1:0];
  assign addr_ok   = 32'(addr_full) < MEM_DEPTH;
  assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign rd_cur    = mem[addr_q];
  assign rd_next   = mem[next_addr];
  assign mem_we    = pend_q & pend_ok_q;
  assign MISO      = miso_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. SS_n high always returns to IDLE. A new frame is
  // accepted only once SS_n has been seen high since reset.
  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (armed_q) state_d = CMD;
        CMD:     state_d = (rx_q[0] != MOSI) ? ADDR : DISCARD;
        ADDR:    if (cnt_q == ADDR_LAST)
                   state_d = !addr_ok ? DISCARD : (rd_q ? RWAIT : WDATA);
        RWAIT:   state_d = RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and output logic. A completed write word is committed one
  // edge after its last bit. This commit is independent of SS_n, so a word
  // finished just before the frame closes is still stored. During a read,
  // the next word is fetched on the edge that shifts out the final bit of
  // the current one. This keeps the stream gap-free.
  always_comb begin
    armed_d   = armed_q | SS_n;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    txpar_d   = txpar_q;
    miso_d    = 1'b0;
    pend_d    = 1'b0;
    pend_ok_d = pend_ok_q;
    wword_d   = wword_q;

    if (pend_q) addr_d = next_addr;

    if (SS_n) begin
      cnt_d = '0;
      rx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            rx_d  = {{(SH_W-1){1'b0}}, MOSI};
            cnt_d = '0;
          end
        end
        CMD: begin
          rd_d  = rx_q[0] & ~MOSI;
          rx_d  = '0;
          cnt_d = '0;
        end
        ADDR: begin
          rx_d  = shift_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d  = '0;
            rx_d   = '0;
            addr_d = addr_full;
          end
        end
        WDATA: begin
          rx_d  = shift_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) wword_d = shift_in[DATA_WIDTH-1:0];
          if (cnt_q == WORD_LAST) begin
            cnt_d  = '0;
            pend_d = 1'b1;
`ifdef SPI_RAM_PARITY_EN
            pend_ok_d = ~(^{wword_q, MOSI});
`else
            pend_ok_d = 1'b1;
`endif
          end
        end
        RWAIT: begin
          tx_d    = rd_cur;
          txpar_d = ^rd_cur;
          cnt_d   = '0;
        end
        RDATA: begin
          miso_d = (cnt_q == PAR_IDX) ? txpar_q : tx_q[DATA_WIDTH-1];
          tx_d   = tx_q << 1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == WORD_LAST) begin
            cnt_d   = '0;
            addr_d  = next_addr;
            tx_d    = rd_next;
            txpar_d = ^rd_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      rx_q      <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      txpar_q   <= 1'b0;
      miso_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_ok_q <= 1'b0;
      wword_q   <= '0;
    end else begin
      armed_q   <= armed_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      txpar_q   <= txpar_d;
      miso_q    <= miso_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      wword_q   <= wword_d;
    end
  end

  // Storage array. It is deliberately left out of reset so contents
  // survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wword_q;
  end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb_spi_ram_burst_slave
//   Bench for spi_ram_burst_slave with default parameters. The reference
//   model is a plain word array, updated per completed burst word. Optional
//   parity bits are sent and expected when SPI_RAM_PARITY_EN is defined.
module tb_spi_ram_burst_slave;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
`ifdef SPI_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n  = 1'b1;
  logic MOSI  = 1'b0;
  logic MISO;

  int checks = 0;
  int errors = 0;

  logic [7:0] refMem [DEPTH];
  logic [7:0] wrData [300];

  always #5 clk = ~clk;

  spi_ram_burst_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(8),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  // Single comparison point: count it, report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit period: inputs change on the falling edge, then we sit
  // just after the rising edge so MISO can be sampled.
  task automatic applyStimulus(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, v[i]);
  endtask

  task automatic endFrame();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_miso", 32'(MISO), 32'd0);
  endtask

  // Burst write of nWords from wrData, optionally followed by a truncated
  // word that must be dropped.
  task automatic spiWrite(input int addr, input int nWords, input int partialBits);
    sendBits(32'd1, 2);
    sendBits(32'(addr), 8);
    for (int w = 0; w < nWords; w++) begin
      sendBits(32'(wrData[w]), 8);
      if (PAR) sendBits(32'(^wrData[w]), 1);
    end
    for (int k = 0; k < partialBits; k++) applyStimulus(1'b0, 1'($urandom));
    endFrame();
    for (int w = 0; w < nWords; w++) refMem[(addr + w) % DEPTH] = wrData[w];
  endtask

  task automatic readHeader(input int addr);
    sendBits(32'd2, 2);
    sendBits(32'(addr), 8);
    applyStimulus(1'b0, 1'($urandom));
    checkOutput("rwait_miso", 32'(MISO), 32'd0);
  endtask

  task automatic spiRead(input int addr, input int nWords);
    logic [7:0] got;
    int a;
    readHeader(addr);
    for (int w = 0; w < nWords; w++) begin
      a = (addr + w) % DEPTH;
      for (int b = 7; b >= 0; b--) begin
        applyStimulus(1'b0, 1'($urandom));
        got[b] = MISO;
      end
      checkOutput($sformatf("rd[%0h]", a), 32'(got), 32'(refMem[a]));
      if (PAR) begin
        applyStimulus(1'b0, 1'($urandom));
        checkOutput("rd_parity", 32'(MISO), 32'(^refMem[a]));
      end
    end
    endFrame();
  endtask

  initial begin
    int start;
    int kind;
    int addr;
    int n;

    // Reset behaviour.
    rst_n = 1'b0;
    SS_n  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_miso", 32'(MISO), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Fill the whole array from a random start (wraps), then read it back
    // from a different offset.
    for (int i = 0; i < DEPTH; i++) wrData[i] = 8'($urandom);
    start = $urandom_range(0, DEPTH - 1);
    spiWrite(start, DEPTH, 0);
    spiRead((start + 100) % DEPTH, DEPTH);

    // Basic write/read pair.
    wrData[0] = 8'hA5; wrData[1] = 8'h3C;
    spiWrite(32'h10, 2, 0);
    spiRead(32'h10, 2);

    // Wrap at the top of the array.
    wrData[0] = 8'h11; wrData[1] = 8'h22;
    spiWrite(32'hFF, 2, 0);
    spiRead(32'hFF, 2);

    // Truncated write word is dropped, next frame works.
    spiWrite(32'h20, 0, 5);
    spiRead(32'h20, 1);

    // Illegal opcode: discarded, MISO stays low.
    sendBits(32'd3, 2);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'($urandom));
      checkOutput("discard_miso", 32'(MISO), 32'd0);
    end
    endFrame();
    spiRead(32'h10, 2);

`ifdef SPI_RAM_PARITY_EN
    // Good parity is stored; bad parity is rejected.
    wrData[0] = 8'hA5;
    spiWrite(32'h05, 1, 0);
    sendBits(32'd1, 2);
    sendBits(32'h06, 8);
    sendBits(32'h5A, 8);
    sendBits(32'd1, 1);
    endFrame();
    spiRead(32'h05, 2);
`endif

    // Randomised mix of bursts.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) wrData[i] = 8'($urandom);
      case (kind)
        0:       spiWrite(addr, n, 0);
        1:       spiRead(addr, n);
        default: spiWrite(addr, n - 1, $urandom_range(1, 7));
      endcase
    end

    // Reset in the middle of a read stream. Then hold SS_n low through the
    // reset release: that frame must be ignored until SS_n goes high.
    readHeader(32'h10);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_miso", 32'(MISO), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sendBits(32'd1, 2);
    sendBits(32'h10, 8);
    sendBits(32'(~refMem[8'h10]), 8);
    if (PAR) sendBits(32'(^(~refMem[8'h10])), 1);
    checkOutput("unarmed_miso", 32'(MISO), 32'd0);
    endFrame();
    spiRead(32'h10, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2ms;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
